// File: rtl/cmd_frame_parser.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : cmd_frame_parser                                             |
// | Description : Byte-level command frame parser for the USB-CDC receive      |
// |               stream.  Frame: AA 55 cmd lenH lenL payload[len] checksum,   |
// |               checksum = 8-bit sum of cmd, lenH, lenL and payload bytes.   |
// |               Payload bytes are streamed out as they arrive; the frame is  |
// |               closed with a cmd_done (checksum good) or cmd_error pulse.   |
// | Optional    : define CMD_PARSER_TIMEOUT_EN to abort a frame after          |
// |               TIMEOUT_CYCLES idle clocks (cmd_error, back to IDLE).        |
// | Ports       : clk, rst_n (async, active low)                               |
// |               usb_data_in[7:0], usb_data_valid_in  - input byte stream     |
// |               cmd_type[7:0], cmd_length[15:0]      - header of frame       |
// |               cmd_data[7:0], cmd_data_index[15:0]  - current payload byte  |
// |               cmd_start, cmd_data_valid, cmd_done, cmd_error - 1-clk pulses|
// |               parser_busy                          - not in IDLE           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module cmd_frame_parser #(
   parameter int MAX_LEN        = 256,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  usb_data_in,
   input  logic        usb_data_valid_in,
   output logic [7:0]  cmd_type,
   output logic [15:0] cmd_length,
   output logic [7:0]  cmd_data,
   output logic [15:0] cmd_data_index,
   output logic        cmd_start,
   output logic        cmd_data_valid,
   output logic        cmd_done,
   output logic        cmd_error,
   output logic        parser_busy
);

   // ------------------------------------------------------------------------
   // State encoding
   // ------------------------------------------------------------------------
   localparam logic [2:0] c_st_idle    = 3'd0;
   localparam logic [2:0] c_st_sync2   = 3'd1;
   localparam logic [2:0] c_st_cmd     = 3'd2;
   localparam logic [2:0] c_st_len_h   = 3'd3;
   localparam logic [2:0] c_st_len_l   = 3'd4;
   localparam logic [2:0] c_st_payload = 3'd5;
   localparam logic [2:0] c_st_check   = 3'd6;

   localparam logic [7:0]  c_sync1   = 8'hAA;
   localparam logic [7:0]  c_sync2   = 8'h55;
   // One extra bit so that MAX_LEN = 65536 still compares correctly.
   localparam logic [16:0] c_max_len = 17'(MAX_LEN);

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   logic [2:0]  r_state;
   logic [7:0]  r_acc;
   logic [7:0]  r_cmd_byte;      // command byte of the frame being parsed
   logic [7:0]  r_len_h;
   logic [15:0] r_index;
   logic [7:0]  r_cmd_type;
   logic [15:0] r_cmd_length;
   logic [7:0]  r_cmd_data;
   logic [15:0] r_cmd_data_index;
   logic        r_cmd_start;
   logic        r_cmd_data_valid;
   logic        r_cmd_done;
   logic        r_cmd_error;

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic [2:0]  w_state_nxt;
   logic [15:0] w_len;
   logic        w_len_over;
   logic        w_last;
   logic [7:0]  w_sum;
   logic        w_chk_ok;
   logic        w_tmo_hit;
   logic        w_start;
   logic        w_data_valid;
   logic        w_done;
   logic        w_error;

   assign w_len      = {r_len_h, usb_data_in};
   assign w_len_over = ({1'b0, w_len} > c_max_len);
   // Only meaningful in PAYLOAD, where r_cmd_length is at least 1.
   assign w_last     = (r_index == (r_cmd_length - 16'd1));
   assign w_sum      = r_acc + usb_data_in;
   assign w_chk_ok   = (usb_data_in == r_acc);

   // ------------------------------------------------------------------------
   // Inter-byte timeout
   // ------------------------------------------------------------------------
`ifdef CMD_PARSER_TIMEOUT_EN
   localparam int                  c_tmo_w    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_tmo_w-1:0]  c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);

   logic [c_tmo_w-1:0] r_tmo;

   // Fires on the idle clock that would bring the count to TIMEOUT_CYCLES.
   assign w_tmo_hit = (r_state != c_st_idle) && !usb_data_valid_in &&
                      (r_tmo == c_tmo_last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tmo <= '0;
      end else if (usb_data_valid_in || (r_state == c_st_idle) || w_tmo_hit) begin
         r_tmo <= '0;
      end else begin
         r_tmo <= r_tmo + c_tmo_w'(1);
      end
   end
`else
   logic w_unused_tmo;

   assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
   assign w_tmo_hit    = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic (advances only on valid bytes)
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      if (usb_data_valid_in) begin
         case (r_state)
            c_st_idle: begin
               if (usb_data_in == c_sync1) w_state_nxt = c_st_sync2;
            end
            c_st_sync2: begin
               // A repeated AA may be the real start of a frame.
               if (usb_data_in == c_sync2)      w_state_nxt = c_st_cmd;
               else if (usb_data_in == c_sync1) w_state_nxt = c_st_sync2;
               else                             w_state_nxt = c_st_idle;
            end
            c_st_cmd:   w_state_nxt = c_st_len_h;
            c_st_len_h: w_state_nxt = c_st_len_l;
            c_st_len_l: begin
               if (w_len_over)         w_state_nxt = c_st_idle;
               else if (w_len == '0)   w_state_nxt = c_st_check;
               else                    w_state_nxt = c_st_payload;
            end
            c_st_payload: begin
               if (w_last) w_state_nxt = c_st_check;
            end
            c_st_check: w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
         endcase
      end else if (w_tmo_hit) begin
         w_state_nxt = c_st_idle;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: output decode (pulse requests, registered below)
   // ------------------------------------------------------------------------
   always_comb begin
      w_start      = 1'b0;
      w_data_valid = 1'b0;
      w_done       = 1'b0;
      w_error      = 1'b0;
      if (usb_data_valid_in) begin
         case (r_state)
            c_st_len_l: begin
               if (w_len_over) w_error = 1'b1;
               else            w_start = 1'b1;
            end
            c_st_payload: w_data_valid = 1'b1;
            c_st_check: begin
               if (w_chk_ok) w_done  = 1'b1;
               else          w_error = 1'b1;
            end
            default: ;
         endcase
      end else if (w_tmo_hit) begin
         w_error = 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Datapath and registered outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc            <= '0;
         r_cmd_byte       <= '0;
         r_len_h          <= '0;
         r_index          <= '0;
         r_cmd_type       <= '0;
         r_cmd_length     <= '0;
         r_cmd_data       <= '0;
         r_cmd_data_index <= '0;
         r_cmd_start      <= 1'b0;
         r_cmd_data_valid <= 1'b0;
         r_cmd_done       <= 1'b0;
         r_cmd_error      <= 1'b0;
      end else begin
         r_cmd_start      <= w_start;
         r_cmd_data_valid <= w_data_valid;
         r_cmd_done       <= w_done;
         r_cmd_error      <= w_error;

         if (usb_data_valid_in) begin
            case (r_state)
               c_st_cmd: begin
                  r_cmd_byte <= usb_data_in;
                  r_acc      <= usb_data_in;
               end
               c_st_len_h: begin
                  r_len_h <= usb_data_in;
                  r_acc   <= w_sum;
               end
               c_st_len_l: begin
                  r_acc <= w_sum;
                  // Header outputs only change for an accepted frame so that
                  // a rejected header cannot disturb a handler's view.
                  if (!w_len_over) begin
                     r_cmd_type   <= r_cmd_byte;
                     r_cmd_length <= w_len;
                     r_index      <= '0;
                  end
               end
               c_st_payload: begin
                  r_cmd_data       <= usb_data_in;
                  r_cmd_data_index <= r_index;
                  r_index          <= r_index + 16'd1;
                  r_acc            <= w_sum;
               end
               c_st_check: begin
                  r_acc <= '0;
               end
               default: ;
            endcase
         end
      end
   end

   assign cmd_type       = r_cmd_type;
   assign cmd_length     = r_cmd_length;
   assign cmd_data       = r_cmd_data;
   assign cmd_data_index = r_cmd_data_index;
   assign cmd_start      = r_cmd_start;
   assign cmd_data_valid = r_cmd_data_valid;
   assign cmd_done       = r_cmd_done;
   assign cmd_error      = r_cmd_error;
   assign parser_busy    = (r_state != c_st_idle);

endmodule
`default_nettype wire
